// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, bus bit constants
// and bit-counter sizing.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    localparam logic BIT_ACK   = 1'b0;
    localparam logic BIT_NACK  = 1'b1;
    localparam int   RW_BIT    = 0;
    localparam int   BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C line: two-flop synchronizer, optional 3-sample majority
// filter (I2C_TARGET_GLITCH_FILTER_EN), then registered level/rise/fall.
module i2c_line_cond (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       clean;
    logic       prev_reg;
    logic       rise_reg;
    logic       fall_reg;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], line};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] win_reg;
    logic       filt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_reg  <= 3'b111;
            filt_reg <= 1'b1;
        end else begin
            win_reg  <= {win_reg[1:0], sync_reg[1]};
            filt_reg <= (win_reg[0] & win_reg[1]) | (win_reg[0] & win_reg[2]) |
                        (win_reg[1] & win_reg[2]);
        end
    end

    assign clean = filt_reg;
`else
    assign clean = sync_reg[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            prev_reg <= clean;
            rise_reg <= clean & ~prev_reg;
            fall_reg <= ~clean & prev_reg;
        end
    end

    assign level = prev_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers with auto-incrementing pointer.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] regOut,
    output logic                  wrStrobe,
    output logic [7:0]            wrIndex,
    output logic                  busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_cond u_scl (
        .clk   (clk),
        .reset (reset),
        .line  (scl),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond u_sda (
        .clk   (clk),
        .reset (reset),
        .line  (sda),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SCL counts as high if it is high now or just fell, so a START/STOP
    // coinciding with an SCL edge takes priority over the edge.
    logic scl_was_high, start_cond, stop_cond;
    assign scl_was_high = scl_level | scl_fall;
    assign start_cond   = sda_fall & scl_was_high;
    assign stop_cond    = sda_rise & scl_was_high;

    i2c_state_t           state_reg, state_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0]           shift_reg, shift_next;
    logic [7:0]           ptr_reg, ptr_next;
    logic                 sda_low_reg, sda_low_next;
    logic                 busy_reg, busy_next;
    logic                 fall_d_reg;
    logic [7:0]           regs [NUM_REGS];

    logic       wr_en;
    logic [7:0] rx_byte;
    logic [7:0] ptr_inc;
    logic [7:0] ptr_load;

    assign rx_byte  = {shift_reg[6:0], sda_level};
    assign ptr_inc  = (ptr_reg == 8'(NUM_REGS - 1)) ? 8'd0 : ptr_reg + 8'd1;
    assign ptr_load = 8'(32'(rx_byte) % NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            sda_low_reg <= 1'b0;
            busy_reg    <= 1'b0;
            fall_d_reg  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            sda_low_reg <= sda_low_next;
            busy_reg    <= busy_next;
            fall_d_reg  <= scl_fall;
            if (wr_en) begin
                regs[ptr_reg[IDX_W-1:0]] <= rx_byte;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        sda_low_next = sda_low_reg;
        busy_next    = busy_reg;
        wr_en        = 1'b0;

        if (stop_cond) begin
            state_next   = ST_IDLE;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
        end else if (start_cond) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '1;
            sda_low_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next = rx_byte;
                        if (bit_cnt_reg == '0) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_next = ST_ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                                busy_next  = 1'b0;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                // First delayed SCL fall starts the ACK, the second ends it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (fall_d_reg) begin
                        if (!sda_low_reg) begin
                            sda_low_next = ~BIT_ACK;
                        end else begin
                            sda_low_next = 1'b0;
                            bit_cnt_next = '1;
                            if (state_reg != ST_ADDR_ACK) begin
                                state_next = ST_WDATA;
                            end else if (shift_reg[RW_BIT]) begin
                                state_next   = ST_RDATA;
                                shift_next   = regs[ptr_reg[IDX_W-1:0]];
                                sda_low_next = ~regs[ptr_reg[IDX_W-1:0]][7];
                            end else begin
                                state_next = ST_PTR;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_next = rx_byte;
                        if (bit_cnt_reg == '0) begin
                            ptr_next   = ptr_load;
                            state_next = ST_PTR_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_next = rx_byte;
                        if (bit_cnt_reg == '0) begin
                            wr_en      = 1'b1;
                            ptr_next   = ptr_inc;
                            state_next = ST_WDATA_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_reg == '0) begin
                            state_next = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 1'b1;
                        end
                    end else if (fall_d_reg) begin
                        sda_low_next = ~shift_reg[bit_cnt_reg];
                    end
                end
                ST_RDATA_ACK: begin
                    if (fall_d_reg) begin
                        sda_low_next = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_level == BIT_NACK) begin
                            state_next = ST_IDLE;
                        end else begin
                            ptr_next     = ptr_inc;
                            state_next   = ST_RDATA;
                            bit_cnt_next = '1;
                            shift_next   = regs[ptr_inc[IDX_W-1:0]];
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign sda      = sda_low_reg ? 1'b0 : 1'bz;
    assign busy     = busy_reg;
    assign wrStrobe = wr_en;
    assign wrIndex  = ptr_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign regOut[8*gi +: 8] = regs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-level I2C master drives the bus,
// expected ACKs/read bytes/write indices go through scoreboard queues.
module tb_i2c_target_regs;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl_m;
    logic        sda_m_low;
    wire         sda;
    logic [31:0] regOut;
    logic        wrStrobe;
    logic [7:0]  wrIndex;
    logic        busy;

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h42), .NUM_REGS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl_m),
        .sda      (sda),
        .regOut   (regOut),
        .wrStrobe (wrStrobe),
        .wrIndex  (wrIndex),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_idx_q[$];
    logic [7:0] obs_idx [256];
    int obs_n    = 0;
    int rd_n     = 0;
    int drv_cnt  = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (wrStrobe === 1'b1 && obs_n < 256) begin
            obs_idx[obs_n] = wrIndex;
            obs_n++;
        end
        if (!sda_m_low && sda === 1'b0) drv_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b1; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_rstart();
        sda_m_low = 1'b0; hq();
        scl_m = 1'b1; hq();
        sda_m_low = 1'b1; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_m_low = 1'b1; hq();
        scl_m = 1'b1; hq();
        sda_m_low = 1'b0; hq(); hq();
    endtask

    task automatic send_bit(input logic b);
        sda_m_low = ~b; hq();
        scl_m = 1'b1; hq(); hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic recv_bit(output logic b);
        sda_m_low = 1'b0; hq();
        scl_m = 1'b1; hq();
        @(negedge clk);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        exp_q.push_back(int'(exp_ack));
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        chk(tag, {31'b0, a}, exp_q.pop_front());
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack, input string tag);
        logic [7:0] d;
        logic b;
        exp_q.push_back(int'(exp));
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(master_ack);
        chk(tag, {24'b0, d}, exp_q.pop_front());
    endtask

    task automatic chk_strobes(input string tag);
        chk({tag, "_count"}, obs_n - rd_n, exp_idx_q.size());
        while (exp_idx_q.size() > 0 && rd_n < obs_n) begin
            chk({tag, "_index"}, {24'b0, obs_idx[rd_n]}, exp_idx_q.pop_front());
            rd_n++;
        end
        rd_n = obs_n;
        exp_idx_q.delete();
    endtask

    initial begin
        int d0, b0;
        logic bit_v;
        reset = 1'b1; scl_m = 1'b1; sda_m_low = 1'b0;
        repeat (5) @(posedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_regOut", regOut, 32'h0);
        chk("rst_wrStrobe", {31'b0, wrStrobe}, 1'b0);
        chk("rst_wrIndex", {24'b0, wrIndex}, 8'h0);
        chk("rst_busy", {31'b0, busy}, 1'b0);
        chk("rst_sda", {31'b0, sda}, 1'b1);
        hq();

        // Write burst: ptr 1, data AA then 55.
        i2c_start();
        write_byte(8'h84, 1'b0, "wr_addr_ack");
        write_byte(8'h01, 1'b0, "wr_ptr_ack");
        exp_idx_q.push_back(1);
        write_byte(8'hAA, 1'b0, "wr_d0_ack");
        exp_idx_q.push_back(2);
        write_byte(8'h55, 1'b0, "wr_d1_ack");
        chk("wr_busy", {31'b0, busy}, 1'b1);
        i2c_stop();
        chk("wr_busy_after_stop", {31'b0, busy}, 1'b0);
        chk("wr_regOut", regOut, 32'h0055AA00);
        chk_strobes("wr_strobe");

        // Seed reg3 and reg0 (write pointer wraps 3 -> 0).
        i2c_start();
        write_byte(8'h84, 1'b0, "seed_addr_ack");
        write_byte(8'h03, 1'b0, "seed_ptr_ack");
        exp_idx_q.push_back(3);
        write_byte(8'hC3, 1'b0, "seed_d0_ack");
        exp_idx_q.push_back(0);
        write_byte(8'h5A, 1'b0, "seed_d1_ack");
        i2c_stop();
        chk_strobes("seed_strobe");
        chk("seed_regOut", regOut, 32'hC355AA5A);

        // Read with repeated START: reg3 then wrap to reg0, ACK then NACK.
        i2c_start();
        write_byte(8'h84, 1'b0, "rd_addr_ack");
        write_byte(8'h03, 1'b0, "rd_ptr_ack");
        i2c_rstart();
        write_byte(8'h85, 1'b0, "rd_raddr_ack");
        chk("rd_busy", {31'b0, busy}, 1'b1);
        read_byte(8'hC3, 1'b0, "rd_byte0");
        read_byte(8'h5A, 1'b1, "rd_byte1");
        d0 = drv_cnt;
        repeat (2 * Q) @(negedge clk);
        chk("rd_release_after_nack", drv_cnt - d0, 0);
        chk("rd_sda_after_nack", {31'b0, sda}, 1'b1);
        i2c_stop();
        chk("rd_busy_after_stop", {31'b0, busy}, 1'b0);
        chk_strobes("rd_strobe");

        // Address mismatch: no ACK, no drive, busy low.
        d0 = drv_cnt;
        b0 = busy_cnt;
        i2c_start();
        write_byte(8'h90, 1'b1, "mm_addr_nack");
        write_byte(8'h00, 1'b1, "mm_data_nack");
        i2c_stop();
        chk("mm_no_drive", drv_cnt - d0, 0);
        chk("mm_busy_never", busy_cnt - b0, 0);
        chk("mm_regOut", regOut, 32'hC355AA5A);
        chk_strobes("mm_strobe");

        // Abort: STOP after 4 data bits of a write to reg2.
        i2c_start();
        write_byte(8'h84, 1'b0, "ab_addr_ack");
        write_byte(8'h02, 1'b0, "ab_ptr_ack");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk("ab_busy", {31'b0, busy}, 1'b0);
        chk("ab_regOut", regOut, 32'hC355AA5A);
        chk_strobes("ab_strobe");

        // Reset while the target drives a 0 data bit (reg1=AA, bit6=0).
        i2c_start();
        write_byte(8'h84, 1'b0, "rr_addr_ack");
        write_byte(8'h01, 1'b0, "rr_ptr_ack");
        i2c_rstart();
        write_byte(8'h85, 1'b0, "rr_raddr_ack");
        recv_bit(bit_v);
        chk("rr_bit7", {31'b0, bit_v}, 1'b1);
        @(negedge clk);
        chk("rr_target_drives0", {31'b0, sda}, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_sda_released", {31'b0, sda}, 1'b1);
        chk("rr_regOut", regOut, 32'h0);
        chk("rr_busy", {31'b0, busy}, 1'b0);
        chk("rr_wrStrobe", {31'b0, wrStrobe}, 1'b0);
        chk("rr_wrIndex", {24'b0, wrIndex}, 8'h0);
        reset = 1'b0;
        scl_m = 1'b1;
        hq(); hq();
        rd_n = obs_n;
        exp_idx_q.delete();

        // 1-clk SCL glitch right after data bit 7 of byte 3C to reg0.
        i2c_start();
        write_byte(8'h84, 1'b0, "gl_addr_ack");
        write_byte(8'h00, 1'b0, "gl_ptr_ack");
        exp_idx_q.push_back(0);
        send_bit(1'b0);
        sda_m_low = 1'b1;
        repeat (3) @(posedge clk);
        scl_m = 1'b1;
        @(posedge clk);
        scl_m = 1'b0;
        repeat (Q - 4) @(posedge clk);
        scl_m = 1'b1; hq(); hq();
        scl_m = 1'b0; hq();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        recv_bit(bit_v);
        i2c_stop();
        chk_strobes("gl_strobe");
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        chk("gl_reg0_filtered", {24'b0, regOut[7:0]}, 8'h3C);
`else
        chk("gl_reg0_corrupted", {24'b0, regOut[7:0]}, 8'h1E);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that presents a small byte-addressed register file to an external I2C master over the shared `sda`/`scl` bus. It is the responder counterpart to the soft-core I2C master and lets the team drive the master against an in-fabric target, or expose FPGA control registers to an off-chip host. It oversamples SCL/SDA on the system clock, detects START/STOP, decodes the 7-bit address, and performs register-pointer writes, data writes and data reads with pointer auto-increment.

## Interface
- `DEV_ADDR`, 7'h42: 7-bit bus address this target answers to.
- `NUM_REGS`, 4: number of 8-bit registers; legal range 1..256.
- `clk` input 1: system clock; must be ≥ 16× the SCL frequency.
- `reset` input 1: synchronous, active-high reset.
- `scl` input 1: bus clock, sampled only. No clock stretching.
- `sda` inout 1: open-drain data. Driven `1'b0` or `1'bz`, never `1'b1`.
- `regOut` output 8·NUM_REGS: flattened register contents; reg *n* is at `[8n+7:8n]`.
- `wrStrobe` output 1: one-`clk` pulse when a data byte is committed to a register.
- `wrIndex` output 8: index written, valid with `wrStrobe`.
- `busy` output 1: high from a START addressed to `DEV_ADDR` until STOP or a non-matching address.

## Operation
- Line conditioning:
  - Two-flop synchronizer on `scl` and `sda`, then edge detection on `scl`.
  - START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
  - A repeated START is handled identically to START.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
  - START from any state goes to ADDR, bit counter = 7. STOP from any state goes to IDLE, releases `sda`, and clears `busy`.
  - ADDR: shift 8 bits on SCL rising edges.
    - Address matches and R/W=0: go to ADDR_ACK, then PTR.
    - Address matches and R/W=1: go to ADDR_ACK, then RDATA.
    - Mismatch: go to IDLE; no ACK is driven.
  - PTR: the received byte loads the pointer, then PTR_ACK. Following bytes go to WDATA.
  - WDATA: on the 8th bit, write the byte to register `ptr`, pulse `wrStrobe`, then WDATA_ACK.
  - RDATA: shift `regOut[ptr]` MSB first. At RDATA_ACK, sample the master's bit on SCL rising:
    - ACK (0): increment `ptr` and continue in RDATA.
    - NACK (1): release `sda` and go to IDLE.
- ACK driving: the target pulls SDA low from the SCL falling edge that ends bit 8 until the next SCL falling edge.
- Pointer:
  - 8-bit register. Increments after each written byte and each ACKed read byte.
  - Wraps from NUM_REGS−1 to 0.
  - A PTR value ≥ NUM_REGS is reduced modulo NUM_REGS when loaded.
- Register file: retains its contents across transactions; only `reset` clears it.

## Timing
- Reset values:
  - `regOut` all zero, `wrStrobe`=0, `wrIndex`=0, `busy`=0, `sda`=z.
  - FSM in IDLE, `ptr`=0.
- Synchronizer latency is 2 `clk`. Edge and condition detection adds 1 `clk`.
- SDA update: on the 2nd `clk` after the SCL falling edge is detected. This gives hold time without violating setup at ≥16× oversampling.
- SDA data is sampled on the `clk` in which the SCL rising edge is detected.
- `wrStrobe` timing:
  - Asserted for exactly 1 `clk`, on the cycle the 8th data bit is sampled.
  - `regOut` reflects the new value on the following cycle.
- Simultaneous SCL edge and START/STOP (both lines changing in the same sample): START/STOP wins.
- `reset` mid-transfer: next cycle is IDLE and `sda` is released, even during an ACK or read bit.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter follows each synchronizer.
  - Pulses ≤1 `clk` wide are rejected.
  - Total input latency becomes 4 `clk`.
- Not defined: no filter; input latency is 2 `clk`.
- All other behaviour is identical in both builds.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum.
  - ACK/NACK bit constants.
  - R/W bit position constant.
  - Bit-counter width.
- One sub-module, `i2c_line_cond`:
  - Synchronizer and optional filter for one line.
  - Outputs the filtered level plus rise and fall pulses.
  - Instantiated for `scl` and for `sda`.
  - START/STOP decode stays in the top level.

## Test plan
- Write burst: START, 0x84, 0x01, 0xAA, 0x55, STOP.
  - ACK on all four bytes.
  - `wrStrobe` pulses with `wrIndex` 1 then 2.
  - `regOut` reg1=0xAA, reg2=0x55.
- Read with repeated START: START, 0x84, 0x03, Sr, 0x85, then read 2 bytes, master ACK then NACK.
  - Returns reg3, then reg0 (pointer wrap).
  - `sda` released after the NACK.
- Address mismatch: START, 0x90, 0x00, STOP.
  - No ACK; `sda` never driven; `busy` stays 0; `regOut` unchanged.
- Abort mid-byte: STOP after 4 data bits of a write.
  - FSM returns to IDLE; no `wrStrobe`; register unchanged.
- Reset during read: assert `reset` while the target is driving a 0 data bit.
  - `sda`=z the next cycle; all outputs at reset values.
- Glitch (filter build): 1-`clk` SCL glitch high during a write.
  - No extra bit is shifted; byte 0x3C is written correctly.
  - Without the filter, the same stimulus corrupts the byte (negative check).
